// File: rtl/imm_decode_stage.sv
// Purpose: decode RISC-V immediates and buffer {inst, pc, imm, fmt, target, illegal} in a small FIFO.
// Latency: one cycle from input accept to valid_o.
// Backpressure: ready_o = (count < DEPTH) from registered state only; the head holds while !ready_i.
//
// Ports:
//   clk, rst            - clock; synchronous active-high reset
//   flush_i             - drop every buffered entry plus any same-cycle input
//   valid_i / ready_o   - upstream handshake with inst_i and pc_i
//   valid_o / ready_i   - downstream handshake with the head entry
//   inst_o, pc_o        - buffered instruction and PC
//   imme_o, fmt_o       - decoded immediate and format code
//   target_o            - pc_o + imme_o
//   illegal_o           - immediate field not legal for DATA_WIDTH

// Purpose: generic circular FIFO with synchronous reset and flush.
// Latency: a push is visible at the head on the next cycle.
// Backpressure: o_push_rdy is low while full. o_pop_dat reads zero while empty.
module imm_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push_vld,
  output logic             o_push_rdy,
  input  logic [WIDTH-1:0] i_push_dat,
  output logic             o_pop_vld,
  input  logic             i_pop_rdy,
  output logic [WIDTH-1:0] o_pop_dat
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign o_push_rdy = (r_count < CNT_W'(DEPTH));
  assign o_pop_vld  = (r_count != '0);
  assign w_push     = i_push_vld && o_push_rdy;
  assign w_pop      = o_pop_vld && i_pop_rdy;

  // Mask the head with the valid flag so an empty buffer reads as all zeros.
  assign o_pop_dat  = o_pop_vld ? r_mem[r_rd_ptr] : '0;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = p + PTR_W'(1);
    end
  endfunction

  // The write slot is never the head slot while entries are present,
  // so a write during a stall does not disturb the outputs.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

module imm_decode_stage #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [31:0]           inst_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [31:0]           inst_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] imme_o,
  output logic [2:0]            fmt_o,
  output logic [DATA_WIDTH-1:0] target_o,
  output logic                  illegal_o
);

  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
    $error("imm_decode_stage: DATA_WIDTH must be 32 or 64");
  end
  if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
    $error("imm_decode_stage: DEPTH must be in 1..8");
  end

  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;
  localparam logic [2:0] FMT_CSR   = 3'd7;

  typedef struct packed {
    logic [31:0]           inst;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] imm;
    logic [2:0]            fmt;
    logic [DATA_WIDTH-1:0] target;
    logic                  illegal;
  } entry_t;

  logic [6:0]            w_opcode;
  logic [2:0]            w_funct3;
  logic                  w_shift_f3;
  logic [63:0]           w_imm64;
  logic [2:0]            w_fmt;
  logic                  w_illegal;
  logic [DATA_WIDTH-1:0] w_imm;
  entry_t                w_push_ent;
  entry_t                w_head_ent;

  assign w_opcode   = inst_i[6:0];
  assign w_funct3   = inst_i[14:12];
  assign w_shift_f3 = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);

  // Every immediate is formed at 64 bits and truncated afterwards, so the
  // sign extension is written once for both datapath widths.
  always_comb begin
    w_imm64   = '0;
    w_fmt     = FMT_NONE;
    w_illegal = 1'b0;
    case (w_opcode)
      7'h13: begin
        if (w_shift_f3) begin
          w_fmt = FMT_SHAMT;
          if (DATA_WIDTH == 64) begin
            w_imm64 = {58'b0, inst_i[25:20]};
          end else begin
            w_imm64   = {59'b0, inst_i[24:20]};
            w_illegal = inst_i[25];
          end
        end else begin
          w_fmt   = FMT_I;
          w_imm64 = {{52{inst_i[31]}}, inst_i[31:20]};
        end
      end
      7'h1b: begin
        // Word ops only exist on RV64, so the whole opcode is illegal at 32 bits.
        if (w_shift_f3) begin
          w_fmt     = FMT_SHAMT;
          w_imm64   = {59'b0, inst_i[24:20]};
          w_illegal = inst_i[25];
        end else begin
          w_fmt   = FMT_I;
          w_imm64 = {{52{inst_i[31]}}, inst_i[31:20]};
        end
        if (DATA_WIDTH == 32) begin
          w_illegal = 1'b1;
        end
      end
      7'h03, 7'h67: begin
        w_fmt   = FMT_I;
        w_imm64 = {{52{inst_i[31]}}, inst_i[31:20]};
      end
      7'h23: begin
        w_fmt   = FMT_S;
        w_imm64 = {{52{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      end
      7'h63: begin
        w_fmt   = FMT_B;
        w_imm64 = {{51{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                   inst_i[11:8], 1'b0};
      end
      7'h6f: begin
        w_fmt   = FMT_J;
        w_imm64 = {{43{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                   inst_i[30:21], 1'b0};
      end
      7'h37, 7'h17: begin
        w_fmt   = FMT_U;
        w_imm64 = {{32{inst_i[31]}}, inst_i[31:12], 12'b0};
      end
      7'h73: begin
        case (w_funct3)
          3'b001, 3'b010, 3'b011: begin
            w_fmt   = FMT_CSR;
            w_imm64 = {52'b0, inst_i[31:20]};
          end
          3'b101, 3'b110, 3'b111: begin
            w_fmt   = FMT_CSR;
            w_imm64 = {59'b0, inst_i[19:15]};
          end
          default: begin
            w_fmt   = FMT_NONE;
            w_imm64 = '0;
          end
        endcase
      end
      default: begin
        w_fmt     = FMT_NONE;
        w_imm64   = '0;
        w_illegal = 1'b0;
      end
    endcase
  end

  assign w_imm = w_imm64[DATA_WIDTH-1:0];

  always_comb begin
    w_push_ent         = '0;
    w_push_ent.inst    = inst_i;
    w_push_ent.pc      = pc_i;
    w_push_ent.imm     = w_imm;
    w_push_ent.fmt     = w_fmt;
    w_push_ent.target  = pc_i + w_imm;
    w_push_ent.illegal = w_illegal;
  end

  // Flush and reset both clear the buffer pointers in the FIFO, and they also
  // block the same-cycle push, so a dropped input never reaches the head.
  imm_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (flush_i),
    .i_push_vld (valid_i),
    .o_push_rdy (ready_o),
    .i_push_dat (w_push_ent),
    .o_pop_vld  (valid_o),
    .i_pop_rdy  (ready_i),
    .o_pop_dat  (w_head_ent)
  );

  assign inst_o    = w_head_ent.inst;
  assign pc_o      = w_head_ent.pc;
  assign imme_o    = w_head_ent.imm;
  assign fmt_o     = w_head_ent.fmt;
  assign target_o  = w_head_ent.target;
  assign illegal_o = w_head_ent.illegal;

endmodule
